// File: rtl/mux_sel_scheduler_pkg.sv
// Shared types and default sizing for the mux select scheduler.
package mux_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_SEL_WIDTH_MUX    = 3;
  localparam int DEF_NUMBER_INPUT_MUX = 8;
  localparam int DEF_DEPTH            = 8;
  localparam int DEF_CNT_WIDTH        = 8;

endpackage

// File: rtl/mux_sel_scheduler_table.sv
// Pattern table: DEPTH select entries, one write port, one combinational read port.
module mux_sel_table
  import mux_sched_pkg::*;
#(
  parameter int SEL_WIDTH_MUX = DEF_SEL_WIDTH_MUX,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AW            = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [SEL_WIDTH_MUX-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic [SEL_WIDTH_MUX-1:0] rdata
);

  logic [SEL_WIDTH_MUX-1:0] mem_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mux_sel_scheduler.sv
// Replays a programmed select pattern REP times into a PE-array operand mux,
// one index per accepted cycle, with stall and abort.
module mux_sel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int SEL_WIDTH_MUX    = DEF_SEL_WIDTH_MUX,
  parameter int NUMBER_INPUT_MUX = DEF_NUMBER_INPUT_MUX,
  parameter int DEPTH            = DEF_DEPTH,
  parameter int CNT_WIDTH        = DEF_CNT_WIDTH,
  parameter int AW               = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we_i,
  input  logic [AW-1:0]            cfg_addr_i,
  input  logic [SEL_WIDTH_MUX-1:0] cfg_sel_i,
  input  logic [AW:0]              cfg_len_i,
  input  logic [CNT_WIDTH-1:0]     cfg_rep_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     stall_i,
  output logic [SEL_WIDTH_MUX-1:0] sel_mux_o,
  output logic                     sel_valid_o,
  output logic                     last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  state_t                   state_reg, state_next;
  logic [AW-1:0]            ptr_reg, ptr_next;
  logic [CNT_WIDTH-1:0]     rep_cnt_reg, rep_cnt_next;
  logic [AW:0]              len_reg, len_next;
  logic [CNT_WIDTH-1:0]     rep_reg, rep_next;
  logic                     err_reg, err_next;
  logic                     table_we;
  logic [SEL_WIDTH_MUX-1:0] table_rdata;

  logic [AW:0]          len_m1;
  logic [CNT_WIDTH-1:0] rep_m1;
  logic                 ptr_at_end;
  logic                 rep_at_end;
  logic                 sel_in_range;
  logic                 len_too_big;

  assign len_m1       = len_reg - 1'b1;
  assign rep_m1       = rep_reg - 1'b1;
  assign ptr_at_end   = ({1'b0, ptr_reg} == len_m1);
  assign rep_at_end   = (rep_cnt_reg == rep_m1);
  assign sel_in_range = (int'({1'b0, cfg_sel_i}) < NUMBER_INPUT_MUX);
  assign len_too_big  = (int'({1'b0, cfg_len_i}) > DEPTH);

  mux_sel_table #(
    .SEL_WIDTH_MUX (SEL_WIDTH_MUX),
    .DEPTH         (DEPTH),
    .AW            (AW)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (table_we),
    .waddr (cfg_addr_i),
    .wdata (cfg_sel_i),
    .raddr (ptr_reg),
    .rdata (table_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      rep_cnt_reg <= '0;
      len_reg     <= '0;
      rep_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      rep_cnt_reg <= rep_cnt_next;
      len_reg     <= len_next;
      rep_reg     <= rep_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    rep_cnt_next = rep_cnt_reg;
    len_next     = len_reg;
    rep_next     = rep_reg;
    err_next     = err_reg;
    table_we     = 1'b0;
    sel_valid_o  = 1'b0;
    busy_o       = 1'b0;
    last_o       = 1'b0;
    done_o       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (len_too_big) begin
            err_next = 1'b1;
          end else if ((cfg_len_i == '0) || (cfg_rep_i == '0)) begin
            state_next = DONE;
          end else begin
            state_next   = RUN;
            len_next     = cfg_len_i;
            rep_next     = cfg_rep_i;
            ptr_next     = '0;
            rep_cnt_next = '0;
            err_next     = 1'b0;
          end
        end
        // A rejected write in the same cycle as a good start still flags the error.
        if (cfg_we_i) begin
          if (sel_in_range) begin
            table_we = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      RUN: begin
        sel_valid_o = 1'b1;
        busy_o      = 1'b1;
        last_o      = ptr_at_end && rep_at_end;
        if (cfg_we_i) begin
          err_next = 1'b1;
        end
        if (abort_i) begin
          state_next = IDLE;
        end else if (!stall_i) begin
          if (ptr_at_end && rep_at_end) begin
            state_next = DONE;
          end
          if (ptr_at_end) begin
            ptr_next     = '0;
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end else begin
            ptr_next = ptr_reg + 1'b1;
          end
        end
      end

      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
        if (cfg_we_i) begin
          err_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign sel_mux_o = (state_reg == RUN) ? table_rdata : '0;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench for mux_sel_scheduler: replay, stall, errors, abort and reset.
module tb_mux_sel_scheduler;

  localparam int SW    = 4;
  localparam int NIN   = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [SW-1:0] cfg_sel;
  logic [AW:0]   cfg_len;
  logic [CW-1:0] cfg_rep;
  logic          start;
  logic          abort;
  logic          stall;
  logic [SW-1:0] sel_mux;
  logic          sel_valid;
  logic          last;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;
  int pat [4];

  always #5 clk = ~clk;

  mux_sel_scheduler #(
    .SEL_WIDTH_MUX    (SW),
    .NUMBER_INPUT_MUX (NIN),
    .DEPTH            (DEPTH),
    .CNT_WIDTH        (CW),
    .AW               (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_sel_i   (cfg_sel),
    .cfg_len_i   (cfg_len),
    .cfg_rep_i   (cfg_rep),
    .start_i     (start),
    .abort_i     (abort),
    .stall_i     (stall),
    .sel_mux_o   (sel_mux),
    .sel_valid_o (sel_valid),
    .last_o      (last),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int sel);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_sel  = SW'(sel);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic go(input int len, input int rep);
    cfg_len = (AW + 1)'(len);
    cfg_rep = CW'(rep);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Checks nrep passes over pat[] with no stall, then the done pulse.
  task automatic run_pat(input string tag, input int nrep);
    for (int i = 0; i < 4 * nrep; i++) begin
      chk({tag, "_valid"}, int'(sel_valid), 1);
      chk({tag, "_sel"}, int'(sel_mux), pat[i % 4]);
      chk({tag, "_last"}, int'(last), (i == 4 * nrep - 1) ? 1 : 0);
      chk({tag, "_done"}, int'(done), 0);
      tick();
    end
    chk({tag, "_donep"}, int'(done), 1);
    chk({tag, "_busyd"}, int'(busy), 0);
    chk({tag, "_vald"}, int'(sel_valid), 0);
    tick();
    chk({tag, "_idle"}, int'(done), 0);
  endtask

  initial begin
    int stall_sel [11];
    int xfers;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0;
    cfg_len = '0; cfg_rep = '0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    #1;
    chk("rst_sel", int'(sel_mux), 0);
    chk("rst_valid", int'(sel_valid), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic replay: {5,2,7,0} x 2
    wr(0, 5); wr(1, 2); wr(2, 7); wr(3, 0);
    pat = '{5, 2, 7, 0};
    chk("pre_start", int'(sel_valid), 0);
    go(4, 2);
    chk("t1_err", int'(err), 0);
    run_pat("t1", 2);

    // Stall for 3 cycles while sel=7
    stall_sel = '{5, 2, 7, 7, 7, 7, 0, 5, 2, 7, 0};
    xfers = 0;
    go(4, 2);
    for (int k = 0; k < 11; k++) begin
      stall = (k >= 2 && k <= 4);
      chk("t2_valid", int'(sel_valid), 1);
      chk("t2_sel", int'(sel_mux), stall_sel[k]);
      if (sel_valid && !stall) xfers++;
      tick();
    end
    stall = 1'b0;
    chk("t2_xfers", xfers, 8);
    chk("t2_done", int'(done), 1);
    tick();

    // Out-of-range write is rejected; later valid start clears err
    wr(1, 9);
    chk("t3_err_set", int'(err), 1);
    go(4, 1);
    chk("t3_err_clr", int'(err), 0);
    run_pat("t3", 1);

    // Zero length -> immediate done; oversize length -> err, no done
    go(0, 3);
    chk("t4_len0_val", int'(sel_valid), 0);
    chk("t4_len0_done", int'(done), 1);
    tick();
    chk("t4_len0_idle", int'(done), 0);
    go(9, 1);
    chk("t4_len9_err", int'(err), 1);
    chk("t4_len9_done", int'(done), 0);
    chk("t4_len9_busy", int'(busy), 0);
    tick();
    chk("t4_len9_done2", int'(done), 0);
    chk("t4_len9_val", int'(sel_valid), 0);

    // Write during RUN flags err and does not disturb the pattern
    go(4, 1);
    chk("t5_err_clr", int'(err), 0);
    chk("t5_sel0", int'(sel_mux), 5);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_sel = 4'd3;
    tick();
    cfg_we = 1'b0;
    chk("t5_err_set", int'(err), 1);
    chk("t5_sel1", int'(sel_mux), 2);
    tick();
    chk("t5_sel2", int'(sel_mux), 7);
    tick();
    chk("t5_sel3", int'(sel_mux), 0);
    chk("t5_last", int'(last), 1);
    tick();
    chk("t5_done", int'(done), 1);
    tick();

    // Abort on the 3rd transfer
    go(4, 2);
    tick();
    tick();
    chk("t6_sel2", int'(sel_mux), 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_valid", int'(sel_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    tick();
    chk("t6_done2", int'(done), 0);

    // Mid-run reset clears outputs immediately and wipes the table
    go(4, 2);
    tick();
    chk("t7_sel1", int'(sel_mux), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_sel", int'(sel_mux), 0);
    chk("t7_valid", int'(sel_valid), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pat = '{0, 0, 0, 0};
    go(4, 1);
    run_pat("t7", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
